// File: rtl/ring_out_port_arbiter.sv
// Output-port controller for one ring link: shares the output channel between pass-through
// and PE injection with per-VC round-robin, one output buffer per VC, polarity-phased.
module ring_out_port_arbiter #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned VC_BIT = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    output logic              so,
    input  logic              ro,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] vc_buf [2];
    logic [1:0]        full;
    logic [1:0]        ptr;

    logic              fill_vc;
    logic              send_vc;
    logic              elig0;
    logic              elig1;
    logic              grant;
    logic [DATA_W-1:0] grant_data;

    // Fill-side arbitration: only packets whose VC matches the current polarity compete.
    always_comb begin
        fill_vc    = polarity;
        send_vc    = ~polarity;
        elig0      = req0 && (data0[VC_BIT] == fill_vc);
        elig1      = req1 && (data1[VC_BIT] == fill_vc);
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (!reset && !full[fill_vc]) begin
            if (elig0 && elig1) begin
                gnt0 = ~ptr[fill_vc];
                gnt1 = ptr[fill_vc];
            end else begin
                gnt0 = elig0;
                gnt1 = elig1;
            end
        end
        grant      = gnt0 | gnt1;
        grant_data = gnt1 ? data1 : data0;
    end

    // Occupancy, pointers and link outputs; fill and send always address different VCs.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= '0;
            ptr  <= '0;
            so   <= 1'b0;
            dout <= '0;
        end else begin
            if (grant) begin
                full[fill_vc] <= 1'b1;
                ptr[fill_vc]  <= gnt0;
            end
            if (full[send_vc] && ro) begin
                so            <= 1'b1;
                dout          <= vc_buf[send_vc];
                full[send_vc] <= 1'b0;
            end else begin
                so   <= 1'b0;
                dout <= '0;
            end
        end
    end

    // Packet storage needs no reset: contents are only observable while full is set.
    always_ff @(posedge clk) begin
        if (grant) begin
            vc_buf[fill_vc] <= grant_data;
        end
    end

endmodule
